ifetch_decode: RTL and testbench

Instruction fetch and field-split stage of the single-cycle processor. Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/ack handshake. Latches the word and presents its decoded fields (opcode, rs, rt, rd, shamt, funct, imm16, jidx) to the downstream stages. imm16 feeds the SIGNEX sign-extension stage directly; the consumer stalls or advances the stage and supplies resolved branch/jump redirects.

---
 rtl/ifetch_decode.sv | 133 +++++++++++++
 tb/tb_ifetch_decode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_decode.sv
// ifetch_decode: instruction fetch and field-split stage.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// latches it in the instruction register and presents its decoded fields.
module ifetch_decode #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jidx,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        fault_q, fault_d;

  // The instruction is handed over only when it is presented and the consumer is ready.
  logic consume;
  assign consume = (state_q == HOLD) && !stall;

  // State register: reset returns to IDLE so that imem_req drops at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE for one cycle, REQ until ack, HOLD until consumed.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (imem_ack) state_d = HOLD;
      HOLD:    if (!stall)   state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: latch the word on ack, advance or redirect the PC on consume.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    if ((state_q == REQ) && imem_ack) begin
      ir_d = imem_rdata;
    end
    if (consume) begin
      if (br_taken) begin
        // Low target bits are dropped; a misaligned redirect is flagged, not trapped.
        pc_d = {br_target[31:2], 2'b00};
        if (br_target[1:0] != 2'b00) begin
          fault_d = 1'b1;
        end
      end else begin
        // 32-bit addition wraps the top of the address space back to zero.
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  // Datapath registers: pc, instruction register and the sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= PC_RESET;
      ir_q    <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  // Output logic: handshake and valid decoded from the state alone.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0000_0000;
    valid     = 1'b0;
    case (state_q)
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
      end
      HOLD:    valid = 1'b1;
      default: ;
    endcase
  end

  // Field outputs are plain slices of ir and keep the old word until the next ack.
  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + PC_STEP;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign jidx     = ir_q[25:0];
  assign fault    = fault_q;

endmodule

// File: tb/tb_ifetch_decode.sv
// tb_ifetch_decode: directed bench for ifetch_decode.
// Instance a runs from PC 0 under directed stimulus; instance b starts at
// 32'hFFFF_FFFC with a zero-wait memory to exercise the PC wrap.
module tb_ifetch_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance a signals
  logic        a_req, a_ack, a_stall, a_br, a_valid, a_fault;
  logic [31:0] a_addr, a_rdata, a_target, a_pc, a_pc4;
  logic [5:0]  a_opcode, a_funct;
  logic [4:0]  a_rs, a_rt, a_rd, a_shamt;
  logic [15:0] a_imm;
  logic [25:0] a_jidx;

  // Instance b signals
  logic        b_req, b_ack, b_stall, b_br, b_valid, b_fault;
  logic [31:0] b_addr, b_rdata, b_target, b_pc, b_pc4;
  logic [5:0]  b_opcode, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
  logic [15:0] b_imm;
  logic [25:0] b_jidx;

  ifetch_decode #(.PC_RESET(32'h0000_0000), .PC_STEP(32'd4)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack), .imem_rdata(a_rdata),
    .stall(a_stall), .br_taken(a_br), .br_target(a_target),
    .valid(a_valid), .pc_out(a_pc), .pc_plus4(a_pc4),
    .opcode(a_opcode), .rs(a_rs), .rt(a_rt), .rd(a_rd), .shamt(a_shamt),
    .funct(a_funct), .imm16(a_imm), .jidx(a_jidx), .fault(a_fault)
  );

  ifetch_decode #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
    .stall(b_stall), .br_taken(b_br), .br_target(b_target),
    .valid(b_valid), .pc_out(b_pc), .pc_plus4(b_pc4),
    .opcode(b_opcode), .rs(b_rs), .rt(b_rt), .rd(b_rd), .shamt(b_shamt),
    .funct(b_funct), .imm16(b_imm), .jidx(b_jidx), .fault(b_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    a_ack = 1'b0; a_rdata = '0; a_stall = 1'b0; a_br = 1'b0; a_target = '0;
    b_ack = 1'b1; b_rdata = 32'h0000_0000; b_stall = 1'b0; b_br = 1'b0; b_target = '0;

    // ---- Reset state ----
    @(negedge clk);
    @(negedge clk);
    check("rst_req",    a_req,    0);
    check("rst_addr",   a_addr,   0);
    check("rst_valid",  a_valid,  0);
    check("rst_pc",     a_pc,     32'h0);
    check("rst_pc4",    a_pc4,    32'h4);
    check("rst_opcode", a_opcode, 0);
    check("rst_jidx",   a_jidx,   0);
    check("rst_fault",  a_fault,  0);
    check("b_rst_pc",   b_pc,     32'hFFFF_FFFC);
    check("b_rst_pc4",  b_pc4,    32'h0);

    // ---- Zero-wait fetch at 0x0 ----
    rst = 1'b0;
    #1;
    check("idle_req", a_req, 0);          // IDLE: first cycle after release
    tick();
    check("req_c2",   a_req,  1);         // request in the 2nd cycle
    check("addr_c2",  a_addr, 32'h0);
    check("b_addr0",  b_addr, 32'hFFFF_FFFC);
    a_ack = 1'b1; a_rdata = 32'h2108_0005;
    tick();
    a_ack = 1'b0;
    check("zw_valid",  a_valid,  1);
    check("zw_req",    a_req,    0);
    check("zw_opcode", a_opcode, 6'h08);
    check("zw_rs",     a_rs,     8);
    check("zw_rt",     a_rt,     8);
    check("zw_imm",    a_imm,    16'h0005);
    check("zw_pc",     a_pc,     32'h0);
    check("zw_pc4",    a_pc4,    32'h4);
    check("b_valid",   b_valid,  1);
    check("b_pc",      b_pc,     32'hFFFF_FFFC);
    check("b_pc4",     b_pc4,    32'h0);
    tick();
    check("next_valid",  a_valid,  0);
    check("next_req",    a_req,    1);
    check("next_addr",   a_addr,   32'h4);
    check("old_opcode",  a_opcode, 6'h08);  // fields hold old ir
    check("b_wrap_addr", b_addr,   32'h0);

    // ---- Three wait cycles at 0x4 ----
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req",   a_req,   1);
      check("wait_addr",  a_addr,  32'h4);
      check("wait_valid", a_valid, 0);
    end
    a_ack = 1'b1; a_rdata = 32'h012A_4020;
    tick();
    a_ack = 1'b0;
    check("ws_valid", a_valid, 1);
    check("ws_pc",    a_pc,    32'h4);
    check("ws_rs",    a_rs,    9);
    check("ws_rt",    a_rt,    10);
    check("ws_rd",    a_rd,    8);
    check("ws_shamt", a_shamt, 0);
    check("ws_funct", a_funct, 6'h20);
    check("ws_jidx",  a_jidx,  26'h12A_4020);

    // ---- Stall for 5 cycles with redirect and stray ack ----
    a_stall = 1'b1; a_br = 1'b1; a_target = 32'h0000_0080;
    a_ack = 1'b1; a_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_valid", a_valid, 1);
      check("st_req",   a_req,   0);
      check("st_pc",    a_pc,    32'h4);
      check("st_funct", a_funct, 6'h20);
      check("st_rd",    a_rd,    8);
    end
    a_ack = 1'b0;

    // ---- Aligned redirect to 0x40 ----
    a_stall = 1'b0; a_br = 1'b1; a_target = 32'h0000_0040;
    tick();
    a_br = 1'b0;
    check("br_valid", a_valid, 0);
    check("br_req",   a_req,   1);
    check("br_addr",  a_addr,  32'h40);
    check("br_fault", a_fault, 0);
    a_ack = 1'b1; a_rdata = 32'h0800_0010;
    tick();
    a_ack = 1'b0;
    check("j_valid",  a_valid,  1);
    check("j_opcode", a_opcode, 6'h02);
    check("j_jidx",   a_jidx,   26'h10);
    check("j_pc",     a_pc,     32'h40);
    check("j_pc4",    a_pc4,    32'h44);

    // ---- Misaligned redirect to 0x42 ----
    a_br = 1'b1; a_target = 32'h0000_0042;
    tick();
    a_br = 1'b0;
    check("mis_addr",  a_addr,  32'h40);
    check("mis_fault", a_fault, 1);
    a_ack = 1'b1; a_rdata = 32'h0000_0000;
    tick();
    a_ack = 1'b0;
    check("mis_valid", a_valid, 1);
    tick();
    check("seq_addr",     a_addr,  32'h44);
    check("fault_sticky", a_fault, 1);

    // ---- Reset while waiting on an ack ----
    tick();
    check("pre_rst_req", a_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_req",   a_req,   0);
    check("async_addr",  a_addr,  0);
    check("async_fault", a_fault, 0);
    check("async_pc",    a_pc,    32'h0);
    @(negedge clk);
    a_ack = 1'b1; a_rdata = 32'hDEAD_BEEF;   // late ack during and after reset
    tick();
    rst = 1'b0;
    tick();
    a_ack = 1'b0;
    check("rs_req",    a_req,    1);
    check("rs_addr",   a_addr,   32'h0);
    check("rs_valid",  a_valid,  0);
    check("rs_opcode", a_opcode, 0);
    tick();
    check("rs_wait_valid", a_valid, 0);
    check("rs_wait_addr",  a_addr,  32'h0);
    a_ack = 1'b1; a_rdata = 32'h2108_0005;
    tick();
    a_ack = 1'b0;
    check("rs_new_valid", a_valid, 1);
    check("rs_new_imm",   a_imm,   16'h0005);
    check("rs_new_pc",    a_pc,    32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
